// File: rtl/pkt_traffic_gen.sv
// pkt_traffic_gen: parameterised packet stream generator.
// Each run emits packets of a fixed byte length. Byte k of packet p is (k+p) mod 256.
// Packets are separated by a programmable number of idle cycles.
// A run ends after pkt_count packets, or at the next packet boundary after a stop pulse.
// Optional feature macro: PKT_GEN_SEQ_HDR_EN.
//   When this macro is defined, bytes 0-3 of every sop word carry the packet index p (little-endian).
module pkt_traffic_gen #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = 3,
    parameter int LEN_W  = 14,
    parameter int CNT_W  = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [CNT_W-1:0]  pkt_count,
    input  logic [7:0]        ipg,
    input  logic              pkt_tx_full,
    output logic [DATA_W-1:0] pkt_tx_data,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [MOD_W-1:0]  pkt_tx_mod,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int BYTES = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        ipg_q;
    logic [7:0]        gap_cnt;
    logic [LEN_W-1:0]  word_idx;
    logic [LEN_W-1:0]  last_idx;
    logic [CNT_W-1:0]  pkt_idx;
    logic              stop_q;

    // A programmed length of zero means a 64-byte packet.
    // The index of the last word is computed once, when the run starts.
    logic [LEN_W-1:0]  len_in;
    logic [LEN_W:0]    words_in;
    logic [LEN_W-1:0]  last_in;
    assign len_in   = (pkt_len == '0) ? LEN_W'(64) : pkt_len;
    assign words_in = ({1'b0, len_in} + (LEN_W+1)'(BYTES - 1)) >> MOD_W;
    assign last_in  = words_in[LEN_W-1:0] - LEN_W'(1);

    logic              last_word;
    logic [CNT_W-1:0]  tx_inc;
    assign last_word = (word_idx == last_idx);
    assign tx_inc    = (&tx_count) ? tx_count : tx_count + CNT_W'(1);

    // Byte index of lane 0 within the packet for the current word.
    logic [LEN_W:0]    base;
    logic [DATA_W-1:0] word_data;
    assign base = {word_idx[LEN_W-MOD_W:0], {MOD_W{1'b0}}};

`ifdef PKT_GEN_SEQ_HDR_EN
    logic [31:0] p32;
    assign p32 = 32'(pkt_idx);
`endif

    // Per-lane byte generator.
    // Bytes past the packet length are zeroed so that the tail of the eop word is clean.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [LEN_W:0] bidx;
            logic [7:0]     pat;
            logic [7:0]     pat_masked;
            assign bidx       = base + (LEN_W+1)'(gi);
            assign pat        = bidx[7:0] + pkt_idx[7:0];
            assign pat_masked = (bidx < {1'b0, len_q}) ? pat : 8'h00;
`ifdef PKT_GEN_SEQ_HDR_EN
            if (gi < 4) begin : g_hdr
                assign word_data[8*gi +: 8] = (word_idx == '0) ? p32[8*gi +: 8] : pat_masked;
            end else begin : g_pat
                assign word_data[8*gi +: 8] = pat_masked;
            end
`else
            assign word_data[8*gi +: 8] = pat_masked;
`endif
        end
    endgenerate

    // Run control FSM and registered output stage.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            ipg_q       <= '0;
            gap_cnt     <= '0;
            word_idx    <= '0;
            last_idx    <= '0;
            pkt_idx     <= '0;
            stop_q      <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    pkt_tx_val <= 1'b0;
                    pkt_tx_sop <= 1'b0;
                    pkt_tx_eop <= 1'b0;
                    pkt_tx_mod <= '0;
                    if (start) begin
                        len_q    <= len_in;
                        last_idx <= last_in;
                        cnt_q    <= pkt_count;
                        ipg_q    <= ipg;
                        word_idx <= '0;
                        pkt_idx  <= '0;
                        tx_count <= '0;
                        stop_q   <= stop;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (stop) stop_q <= 1'b1;
                    if (pkt_tx_full) begin
                        // Back-pressure: hold the word pointer, so the pending word is emitted later.
                        pkt_tx_val <= 1'b0;
                        pkt_tx_sop <= 1'b0;
                        pkt_tx_eop <= 1'b0;
                        pkt_tx_mod <= '0;
                    end else begin
                        pkt_tx_val  <= 1'b1;
                        pkt_tx_data <= word_data;
                        pkt_tx_sop  <= (word_idx == '0);
                        pkt_tx_eop  <= last_word;
                        pkt_tx_mod  <= last_word ? len_q[MOD_W-1:0] : '0;
                        if (!last_word) begin
                            word_idx <= word_idx + LEN_W'(1);
                        end else begin
                            word_idx <= '0;
                            pkt_idx  <= pkt_idx + CNT_W'(1);
                            tx_count <= tx_inc;
                            if (stop_q || stop || (cnt_q != '0 && tx_inc == cnt_q)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (ipg_q != 8'd0) begin
                                gap_cnt <= ipg_q;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    pkt_tx_val <= 1'b0;
                    pkt_tx_sop <= 1'b0;
                    pkt_tx_eop <= 1'b0;
                    pkt_tx_mod <= '0;
                    if (stop_q || stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == 8'd1) begin
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_traffic_gen.sv
// Testbench for pkt_traffic_gen (DATA_W=64).
// An expected word stream for each run is built from the byte-pattern rules.
// A monitor compares every valid word against that stream.
// Directed literal checks pin the expected values.
module tb_pkt_traffic_gen;

    localparam int DATA_W = 64;
    localparam int MOD_W  = 3;
    localparam int LEN_W  = 14;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [LEN_W-1:0]  pkt_len = '0;
    logic [CNT_W-1:0]  pkt_count = '0;
    logic [7:0]        ipg = '0;
    logic              full = 1'b0;
    logic [DATA_W-1:0] data;
    logic              val, sop, eop, busy, done;
    logic [MOD_W-1:0]  mod;
    logic [CNT_W-1:0]  tx_count;

    pkt_traffic_gen #(.DATA_W(DATA_W), .MOD_W(MOD_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .start(start), .stop(stop),
        .pkt_len(pkt_len), .pkt_count(pkt_count), .ipg(ipg), .pkt_tx_full(full),
        .pkt_tx_data(data), .pkt_tx_val(val), .pkt_tx_sop(sop), .pkt_tx_eop(eop),
        .pkt_tx_mod(mod), .busy(busy), .done(done), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_data_q[$];
    bit          exp_sop_q[$];
    bit          exp_eop_q[$];
    int          exp_mod_q[$];

    // Observations gathered by the monitor
    int          cyc = 0;
    int          word_cnt = 0;
    int          done_cnt = 0;
    int          sop_cyc = 0;
    int          last_eop_cyc = -1;
    int          gap_q[$];
    int          span_q[$];
    logic [63:0] sop_data_q[$];
    logic [7:0]  eop_b0_q[$];
    int          eop_mod_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Expected word stream for one run: npkts packets of len bytes each.
    task automatic model_run(input int len, input int npkts);
        int eff;
        int words;
        int b;
        logic [63:0] d;
        logic [7:0] byt;
        eff   = (len == 0) ? 64 : len;
        words = (eff * 8 + DATA_W - 1) / DATA_W;
        for (int p = 0; p < npkts; p++) begin
            for (int w = 0; w < words; w++) begin
                d = '0;
                for (int k = 0; k < 8; k++) begin
                    b   = w * 8 + k;
                    byt = (b < eff) ? 8'((b + p) % 256) : 8'h00;
`ifdef PKT_GEN_SEQ_HDR_EN
                    if (w == 0 && k < 4) byt = 8'((p >> (8 * k)) & 255);
`endif
                    d[8*k +: 8] = byt;
                end
                exp_data_q.push_back(d);
                exp_sop_q.push_back(w == 0);
                exp_eop_q.push_back(w == words - 1);
                exp_mod_q.push_back((w == words - 1) ? eff % 8 : 0);
            end
        end
    endtask

    // Monitor: compare every valid word against the expected stream.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (done) done_cnt++;
            if (val) begin
                word_cnt++;
                if (exp_data_q.size() == 0) begin
                    check("extra_word", 64'd1, 64'd0);
                end else begin
                    check("word_data", data, exp_data_q.pop_front());
                    check("word_sop", 64'(sop), 64'(exp_sop_q.pop_front()));
                    check("word_eop", 64'(eop), 64'(exp_eop_q.pop_front()));
                    check("word_mod", 64'(mod), 64'(exp_mod_q.pop_front()));
                end
                if (sop) begin
                    sop_cyc = cyc;
                    sop_data_q.push_back(data);
                    if (last_eop_cyc >= 0) gap_q.push_back(cyc - last_eop_cyc - 1);
                end
                if (eop) begin
                    eop_b0_q.push_back(data[7:0]);
                    eop_mod_q.push_back(int'(mod));
                    span_q.push_back(cyc - sop_cyc + 1);
                    last_eop_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_obs();
        word_cnt = 0;
        last_eop_cyc = -1;
        gap_q.delete();
        span_q.delete();
        sop_data_q.delete();
        eop_b0_q.delete();
        eop_mod_q.delete();
    endtask

    task automatic do_start(input int len, input int cnt, input int gap, input bit with_stop);
        @(negedge clk);
        pkt_len   = LEN_W'(len);
        pkt_count = CNT_W'(cnt);
        ipg       = 8'(gap);
        start     = 1'b1;
        stop      = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic wait_words(input string name, input int target, input int budget);
        int n = 0;
        while (word_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (word_cnt < target) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic end_of_run(input string name, input int exp_cnt);
        check({name, "_tx_count"}, 64'(tx_count), 64'(exp_cnt));
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_leftover"}, 64'(exp_data_q.size()), 64'd0);
    endtask

    int d0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_val", 64'(val), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_busy_done", 64'({busy, done, sop, eop}), 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: len 64, count 1 -> 8 words
        clear_obs();
        model_run(64, 1);
        d0 = done_cnt;
        do_start(64, 1, 0, 0);
        wait_done("r1", d0, 50);
`ifdef PKT_GEN_SEQ_HDR_EN
        check("r1_word0", sop_data_q[0], 64'h0706050400000000);
`else
        check("r1_word0", sop_data_q[0], 64'h0706050403020100);
`endif
        check("r1_words", 64'(word_cnt), 64'd8);
        check("r1_mod", 64'(eop_mod_q[0]), 64'd0);
        end_of_run("r1", 1);
        @(negedge clk);
        #1;
        check("r1_done_one_cycle", 64'(done), 64'd0);

        // Run 2: len 65, count 2, ipg 3. A second start mid-run must be ignored.
        clear_obs();
        model_run(65, 2);
        d0 = done_cnt;
        do_start(65, 2, 3, 0);
        repeat (3) @(negedge clk);
        pkt_len = LEN_W'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("r2", d0, 80);
        check("r2_words", 64'(word_cnt), 64'd18);
        check("r2_eop_b0_p0", 64'(eop_b0_q[0]), 64'h40);
        check("r2_eop_b0_p1", 64'(eop_b0_q[1]), 64'h41);
        check("r2_mod", 64'(eop_mod_q[1]), 64'd1);
        check("r2_gap", 64'(gap_q[0]), 64'd3);
        end_of_run("r2", 2);

        // Run 3: back-pressure for 5 cycles in the middle of the packet
        clear_obs();
        model_run(64, 1);
        d0 = done_cnt;
        do_start(64, 1, 0, 0);
        wait_words("r3", 3, 20);
        full = 1'b1;
        repeat (5) @(negedge clk);
        full = 1'b0;
        wait_done("r3", d0, 50);
        check("r3_span", 64'(span_q[0]), 64'd13);
        end_of_run("r3", 1);

        // Run 4: one-word packets, back to back
        clear_obs();
        model_run(5, 3);
        d0 = done_cnt;
        do_start(5, 3, 0, 0);
        wait_done("r4", d0, 50);
        check("r4_gap", 64'(gap_q[0] + gap_q[1]), 64'd0);
        check("r4_mod", 64'(eop_mod_q[2]), 64'd5);
`ifdef PKT_GEN_SEQ_HDR_EN
        check("r4_hdr0", 64'(sop_data_q[0][31:0]), 64'd0);
        check("r4_hdr1", 64'(sop_data_q[1][31:0]), 64'd1);
        check("r4_hdr2", 64'(sop_data_q[2][31:0]), 64'd2);
`else
        check("r4_low0", 64'(sop_data_q[0][31:0]), 64'h03020100);
        check("r4_low1", 64'(sop_data_q[1][31:0]), 64'h04030201);
        check("r4_low2", 64'(sop_data_q[2][31:0]), 64'h05040302);
`endif
        end_of_run("r4", 3);

        // Run 5: continuous run, stop while word 3 of packet 10 is on the bus
        clear_obs();
        model_run(64, 11);
        d0 = done_cnt;
        do_start(64, 0, 1, 0);
        wait_words("r5", 84, 300);
        pulse_stop();
        wait_done("r5", d0, 50);
        check("r5_gap", 64'(gap_q[5]), 64'd1);
        end_of_run("r5", 11);

        // Run 6: start and stop together -> exactly one packet
        clear_obs();
        model_run(16, 1);
        d0 = done_cnt;
        do_start(16, 5, 0, 1);
        wait_done("r6", d0, 50);
        repeat (5) @(negedge clk);
        end_of_run("r6", 1);

        // Run 7: stop during the inter-packet gap
        clear_obs();
        model_run(8, 1);
        d0 = done_cnt;
        do_start(8, 0, 6, 0);
        wait_words("r7", 1, 20);
        @(negedge clk);
        pulse_stop();
        wait_done("r7", d0, 20);
        repeat (10) @(negedge clk);
        end_of_run("r7", 1);

        // Run 8: asynchronous reset at word 4
        clear_obs();
        model_run(64, 1);
        do_start(64, 1, 0, 0);
        wait_words("r8", 5, 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("r8_rst_val", 64'(val), 64'd0);
        check("r8_rst_data", data, 64'd0);
        check("r8_rst_flags", 64'({busy, done, sop, eop, mod}), 64'd0);
        check("r8_rst_tx_count", 64'(tx_count), 64'd0);
        @(negedge clk);
        exp_data_q.delete();
        exp_sop_q.delete();
        exp_eop_q.delete();
        exp_mod_q.delete();
        word_cnt = 0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("r8_no_val_after_reset", 64'(word_cnt), 64'd0);
        check("r8_busy_after_reset", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_traffic_gen.md
PKT_TRAFFIC_GEN -- requirements
Module: pkt_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 64, packet word width in bits (64, 128 or 256).
REQ-002 SHALL have parameter MOD_W, default 3, equal to log2(DATA_W/8).
REQ-003 SHALL have parameter LEN_W, default 14, width of the byte-length field.
REQ-004 SHALL have parameter CNT_W, default 32, width of the packet count and transmitted-count fields.
REQ-005 clk_156m25  in  1  sole clock; all logic is on its rising edge.
REQ-006 reset_156m25_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins a run.
REQ-008 stop  in  1  single-cycle pulse requesting graceful end of the run.
REQ-009 pkt_len  in  LEN_W  packet length in bytes, sampled at start.
REQ-010 pkt_count  in  CNT_W  packets per run, sampled at start; 0 = continuous.
REQ-011 ipg  in  8  idle cycles between packets, sampled at start.
REQ-012 pkt_tx_full  in  1  downstream TX FIFO full.
REQ-013 pkt_tx_data  out  DATA_W  packet word; byte k sits in bits [8k+7:8k].
REQ-014 pkt_tx_val / pkt_tx_sop / pkt_tx_eop  out  1 each  word valid / first word / last word.
REQ-015 pkt_tx_mod  out  MOD_W  valid bytes in the last word modulo DATA_W/8; 0 = all bytes valid.
REQ-016 busy  out  1  a run is in progress.
REQ-017 done  out  1  one-cycle pulse when a run ends.
REQ-018 tx_count  out  CNT_W  packets completed since the last start.

Function
REQ-019 SHALL implement the FSM states IDLE, SEND, GAP; all outputs SHALL be registered.
REQ-020 IDLE: start=1 SHALL latch the parameters, clear tx_count and set busy; the sop word SHALL appear on the next clock edge (latency 1).
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 pkt_len=0 SHALL be treated as 64.
REQ-023 Words per packet SHALL be ceil(pkt_len*8/DATA_W); a one-word packet SHALL assert sop and eop together.
REQ-024 Byte k of packet p SHALL be (k+p) mod 256, with p counted from 0 within the run; bytes past the packet length in the eop word SHALL be 0.
REQ-025 In the eop word, pkt_tx_mod SHALL be pkt_len mod (DATA_W/8); in all other words it SHALL be 0.
REQ-026 If pkt_tx_full=1 at an edge, the next cycle SHALL have pkt_tx_val=0 and the pending word SHALL be held unchanged; no word SHALL be skipped or duplicated.
REQ-027 On eop, tx_count SHALL increment by 1 in the same edge.
REQ-028 After eop, the FSM SHALL enter GAP for ipg cycles with val=0, then return to SEND; ipg=0 SHALL give back-to-back packets with no GAP cycle.
REQ-029 The run SHALL end when tx_count reaches pkt_count (pkt_count≠0), or after the eop following a stop; at run end the FSM SHALL return to IDLE, clear busy and pulse done.
REQ-030 stop SHALL be latched; a stop received in GAP or IDLE-return SHALL end the run without starting a new packet.
REQ-031 A stop received mid-packet SHALL let that packet complete.
REQ-032 tx_count SHALL saturate at its maximum value rather than wrap.
REQ-033 start and stop asserted in the same cycle from IDLE SHALL send exactly one packet.

Reset
REQ-034 Asserting reset_156m25_n=0 SHALL immediately force state IDLE and drive every output to 0, including mid-packet.
REQ-035 After reset, no packet activity SHALL occur until the next start pulse.

Configuration
REQ-036 When PKT_GEN_SEQ_HDR_EN is defined, bytes 0-3 of every sop word SHALL carry the packet index p as a little-endian value, replacing the pattern bytes; the remaining bytes SHALL still follow REQ-024.
REQ-037 When PKT_GEN_SEQ_HDR_EN is undefined, the pattern of REQ-024 SHALL apply to all bytes.

Verification
REQ-038 DATA_W=64, len=64, count=1 -> 8 words; word0=0x0706050403020100; eop on word 7 with mod=0; done pulses; tx_count=1.
REQ-039 DATA_W=64, len=65, count=2, ipg=3 -> 9 words per packet; eop word byte0=0x40 (pkt0) and 0x41 (pkt1), mod=1; exactly 3 val=0 cycles between the packets.
REQ-040 pkt_tx_full held high for 5 cycles mid-packet -> val=0 for 5 cycles; word sequence is contiguous with no loss or duplication.
REQ-041 count=0 and stop at word 3 of packet 10 -> packet 10 completes; tx_count=11; busy drops; done pulses.
REQ-042 reset_156m25_n asserted at word 4 -> all outputs 0 immediately; after release, no val until start.
REQ-043 PKT_GEN_SEQ_HDR_EN defined, count=3 -> sop words low 32 bits = 0, 1, 2.
